// File: rtl/lcd_line_scanout_if.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_line_scanout_if
//  Description : Line-buffer link between the pixel-side scanout and the
//                line buffer / producer (read port plus line request).
//  Revision    : 1.0 - initial release
// ============================================================================
interface lcd_line_scanout_if;
    logic [9:0]  rd_addr;
    logic [23:0] rd_data;
    logic [9:0]  y_pos;
    logic        line_request;

    modport master (
        output rd_addr,
        input  rd_data,
        output y_pos,
        output line_request
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        input  y_pos,
        input  line_request
    );
endinterface
`default_nettype wire

// File: rtl/lcd_line_scanout.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_line_scanout
//  Description : LCD timing generator and line-buffer reader; requests each
//                upcoming line and drives RGB565 with 2-cycle output latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_line_scanout #(
    parameter int H_RES   = 800,
    parameter int H_FP    = 40,
    parameter int H_SYNC  = 48,
    parameter int H_BP    = 88,
    parameter int V_RES   = 480,
    parameter int V_FP    = 13,
    parameter int V_SYNC  = 3,
    parameter int V_BP    = 32,
    parameter int REQ_LEN = 8
) (
    input  wire logic           clk_pixel,
    input  wire logic           rst_n,
    lcd_line_scanout_if.master  lb,
    output logic                LCD_HSYNC,
    output logic                LCD_VSYNC,
    output logic                LCD_DEN,
    output logic [4:0]          LCD_R,
    output logic [5:0]          LCD_G,
    output logic [4:0]          LCD_B
);

    localparam int c_H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
    localparam int c_CW      = 11;
    localparam int c_RW      = $clog2(REQ_LEN) + 1;

    localparam logic [c_CW-1:0] c_H_RES    = c_CW'(H_RES);
    localparam logic [c_CW-1:0] c_H_LAST   = c_CW'(c_H_TOTAL - 1);
    localparam logic [c_CW-1:0] c_HS_START = c_CW'(H_RES + H_FP);
    localparam logic [c_CW-1:0] c_HS_END   = c_CW'(H_RES + H_FP + H_SYNC);
    localparam logic [c_CW-1:0] c_V_RES    = c_CW'(V_RES);
    localparam logic [c_CW-1:0] c_V_LAST   = c_CW'(c_V_TOTAL - 1);
    localparam logic [c_CW-1:0] c_VS_START = c_CW'(V_RES + V_FP);
    localparam logic [c_CW-1:0] c_VS_END   = c_CW'(V_RES + V_FP + V_SYNC);
    localparam logic [c_RW-1:0] c_REQ_LAST = c_RW'(REQ_LEN - 1);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_REQ  = 1'b1;

    logic [c_CW-1:0] r_h_cnt;
    logic [c_CW-1:0] r_v_cnt;
    logic [c_CW-1:0] w_v_next;
    logic            w_den;
    logic            w_hsync_n;
    logic            w_vsync_n;
    logic            r_den_d1;
    logic            r_hs_d1;
    logic            r_vs_d1;
    logic [0:0]      r_state;
    logic [c_RW-1:0] r_req_cnt;
    logic [9:0]      r_y_pos;
    logic            r_line_request;

    // Reset lands on the request point for line 0 (last line of the frame, h = H_RES)
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= c_H_RES;
            r_v_cnt <= c_V_LAST;
        end else if (r_h_cnt == c_H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_next;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    assign w_v_next  = (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + 1'b1;
    assign w_den     = (r_h_cnt < c_H_RES) && (r_v_cnt < c_V_RES);
    assign w_hsync_n = !((r_h_cnt >= c_HS_START) && (r_h_cnt < c_HS_END));
    assign w_vsync_n = !((r_v_cnt >= c_VS_START) && (r_v_cnt < c_VS_END));

    assign lb.rd_addr      = w_den ? r_h_cnt[9:0] : 10'd0;
    assign lb.y_pos        = r_y_pos;
    assign lb.line_request = r_line_request;

    // Stage 1 matches the RAM read latency; stage 2 registers the panel pins
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_den_d1  <= 1'b0;
            r_hs_d1   <= 1'b1;
            r_vs_d1   <= 1'b1;
            LCD_DEN   <= 1'b0;
            LCD_HSYNC <= 1'b1;
            LCD_VSYNC <= 1'b1;
            LCD_R     <= '0;
            LCD_G     <= '0;
            LCD_B     <= '0;
        end else begin
            r_den_d1  <= w_den;
            r_hs_d1   <= w_hsync_n;
            r_vs_d1   <= w_vsync_n;
            LCD_DEN   <= r_den_d1;
            LCD_HSYNC <= r_hs_d1;
            LCD_VSYNC <= r_vs_d1;
            LCD_R     <= r_den_d1 ? lb.rd_data[23:19] : 5'd0;
            LCD_G     <= r_den_d1 ? lb.rd_data[15:10] : 6'd0;
            LCD_B     <= r_den_d1 ? lb.rd_data[7:3]   : 5'd0;
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= c_S_IDLE;
            r_req_cnt      <= '0;
            r_y_pos        <= '0;
            r_line_request <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if ((r_h_cnt == c_H_RES) && (w_v_next < c_V_RES)) begin
                        r_state        <= c_S_REQ;
                        r_req_cnt      <= '0;
                        r_y_pos        <= w_v_next[9:0];
                        r_line_request <= 1'b1;
                    end
                end
                c_S_REQ: begin
                    if (r_req_cnt == c_REQ_LAST) begin
                        r_state        <= c_S_IDLE;
                        r_line_request <= 1'b0;
                    end else begin
                        r_req_cnt <= r_req_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state        <= c_S_IDLE;
                    r_line_request <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
